four_to_two_event_encoder: RTL and testbench
============================================

// Module: four_to_two_event_encoder
//
// PURPOSE
// Sequential 4-to-2 encoder; the inverse of the 2-to-4 decoder. Detects rising edges on four
// event lines, queues one pending flag per line and emits each event as a 2-bit code over a
// valid/ready handshake. Used wherever four decoded strobes must be folded back into a code.
//
// PARAMETERS
// ROUND_ROBIN  0  0: fixed priority, line 0 highest; 1: rotating priority after last grant
// CNT_W        8  width of saturating overflow (dropped-event) counter, >= 1
//
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      asynchronous reset, active-high
// d          in   4      event lines, synchronous to clk; rise on d[i] = event on line i
// out_code   out  2      encoded index of the event being presented
// out_valid  out  1      out_code holds an event
// out_ready  in   1      consumer accepts out_code when out_valid & out_ready at a clk edge
// busy       out  1      |pending | out_valid (combinational from regs)
// ovf_cnt    out  CNT_W  count of dropped events, saturates at all-ones
// ovf_clr    in   1      synchronous clear of ovf_cnt
//
// BEHAVIOUR
// - Reset (async, any time incl. mid-transfer): d_q=0, pending=0, out_valid=0, out_code=0,
//   ovf_cnt=0, rr_ptr=0. Events in flight are discarded, no partial state survives.
// - Edge detect: rise[i] = d[i] & ~d_q[i]; d_q <= d every edge. Level held high = one event.
// - Pending: at an edge, pending[i] set if rise[i]; cleared if line i is loaded to output.
//   Set and clear on the same line same edge -> pending[i] stays 1 (new event kept).
// - Drop: rise[i] while pending[i]=1 and line i not loaded that edge -> event lost,
//   ovf_cnt += 1 (saturating). Multiple drops same edge: +1 per dropped line, still saturating.
//   ovf_clr wins over increments at the same edge (counter -> 0).
// - Load: output slot free = ~out_valid | out_ready. If free and pending!=0: out_code <= sel,
//   out_valid <= 1, pending[sel] cleared. If free and pending==0: out_valid <= 0.
//   Otherwise out_code/out_valid hold; out_code must not change while out_valid & ~out_ready.
// - Select, ROUND_ROBIN=0: lowest set index of pending.
//   ROUND_ROBIN=1: first set index searching rr_ptr, rr_ptr+1, ... mod 4; on load rr_ptr <= sel+1
//   (mod 4, 3 wraps to 0).
// - Latency: rise visible at d before edge N -> pending at N -> out_valid=1 after N+1 (2 edges)
//   when the slot is free. Throughput one event per clk with out_ready held 1.
// - Pending reads only registered pending (no bypass of rise into output).
// - Fully synchronous datapath; only rst is asynchronous.
//
// TESTING
// 1 Reset: rst=1 mid-stream with out_valid=1, pending=4'b1010 -> all outputs 0 immediately,
//   after release busy=0, ovf_cnt=0.
// 2 Single event: out_ready=1, d 0000->0100 and held -> out_valid=1 with out_code=2 exactly
//   2 edges later, for one cycle only; no repeat while d stays high.
// 3 Fixed priority: ROUND_ROBIN=0, d 0000->1111 one edge, out_ready=1 -> codes 0,1,2,3 on
//   consecutive cycles, then out_valid=0, busy=0.
// 4 Backpressure: out_ready=0, event on line 3 -> out_valid=1, out_code=3 stable 10 cycles;
//   pulse line 3 again twice while stalled -> first pends, second drops, ovf_cnt=1.
// 5 Round robin: ROUND_ROBIN=1, all four lines pulsed repeatedly every cycle, out_ready=1 ->
//   grant order 0,1,2,3,0,...; no line starved.
// 6 Overflow: CNT_W=2, force 5 drops -> ovf_cnt 1,2,3,3,3; ovf_clr with a drop same edge -> 0.

Source files
------------

// File: rtl/four_to_two_event_encoder.sv
// four_to_two_event_encoder: folds rising edges on four event lines into a 2-bit code over valid/ready.
module four_to_two_event_encoder #(
  parameter int ROUND_ROBIN = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       d,
  output logic [1:0]       out_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);
  logic [3:0] d_q, pending, rise, rot, load_mask, drop;
  logic [1:0] rr_ptr, sel, base;
  logic free, load;
  logic [CNT_W+2:0] ovf_sum;
  logic [CNT_W-1:0] ovf_nxt;
  function automatic logic [1:0] lowest(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
  // Round robin rotates pending so the search starts at rr_ptr, then maps back.
  always_comb begin
    rise = d & ~d_q;
    base = (ROUND_ROBIN != 0) ? rr_ptr : 2'd0;
    rot = 4'({pending, pending} >> base);
    sel = base + lowest(rot);
    free = ~out_valid | out_ready;
    load = free & |pending;
    load_mask = load ? 4'b0001 << sel : 4'b0000;
    drop = rise & pending & ~load_mask;
    ovf_sum = (CNT_W+3)'(ovf_cnt) + (CNT_W+3)'(drop[0]) + (CNT_W+3)'(drop[1])
            + (CNT_W+3)'(drop[2]) + (CNT_W+3)'(drop[3]);
    ovf_nxt = ovf_clr ? '0 : (|ovf_sum[CNT_W+2:CNT_W]) ? '1 : ovf_sum[CNT_W-1:0];
    busy = |pending | out_valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
      pending <= '0;
      out_valid <= 1'b0;
      out_code <= '0;
      ovf_cnt <= '0;
      rr_ptr <= '0;
    end else begin
      d_q <= d;
      pending <= (pending & ~load_mask) | rise;
      ovf_cnt <= ovf_nxt;
      if (free) out_valid <= load;
      if (load) begin
        out_code <= sel;
        rr_ptr <= sel + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_four_to_two_event_encoder.sv
// tb_four_to_two_event_encoder: directed checks of a fixed-priority, a round-robin and a 2-bit-counter instance.
module tb_four_to_two_event_encoder;
  logic clk = 1'b0, rst, out_ready, ovf_clr;
  logic [3:0] d;
  logic [1:0] code_a, code_b, code_c, ovf_c;
  logic valid_a, valid_b, valid_c, busy_a, busy_b, busy_c;
  logic [7:0] ovf_a, ovf_b;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  four_to_two_event_encoder #(.ROUND_ROBIN(0), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .d(d),
    .out_code(code_a), .out_valid(valid_a), .out_ready(out_ready), .busy(busy_a), .ovf_cnt(ovf_a), .ovf_clr(ovf_clr));
  four_to_two_event_encoder #(.ROUND_ROBIN(1), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .d(d),
    .out_code(code_b), .out_valid(valid_b), .out_ready(out_ready), .busy(busy_b), .ovf_cnt(ovf_b), .ovf_clr(ovf_clr));
  four_to_two_event_encoder #(.ROUND_ROBIN(0), .CNT_W(2)) dut_c (.clk(clk), .rst(rst), .d(d),
    .out_code(code_c), .out_valid(valid_c), .out_ready(out_ready), .busy(busy_c), .ovf_cnt(ovf_c), .ovf_clr(ovf_clr));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    d = 4'b0000;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    out_ready = 1'b0;
    d = 4'b1011;
    step();
    n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL rst_no_bypass: got %b want 0", valid_a); end
    step();
    n_cmp++; if ({valid_a, code_a} !== 3'b100) begin n_err++; $display("FAIL rst_setup: got %b want 100", {valid_a, code_a}); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({valid_a, code_a, busy_a, ovf_a} !== 12'h0) begin n_err++; $display("FAIL rst_async: got %h want 000", {valid_a, code_a, busy_a, ovf_a}); end
    d = 4'b0000;
    step();
    rst = 1'b0;
    step();
    n_cmp++; if ({busy_a, busy_b, busy_c, ovf_a} !== 11'h0) begin n_err++; $display("FAIL rst_release: got %h want 000", {busy_a, busy_b, busy_c, ovf_a}); end
  endtask
  task automatic test_single();
    out_ready = 1'b1;
    d = 4'b0100;
    step();
    n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL single_early: got %b want 0", valid_a); end
    step();
    n_cmp++; if ({valid_a, code_a} !== 3'b110) begin n_err++; $display("FAIL single_out: got %b want 110", {valid_a, code_a}); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({valid_a, busy_a} !== 2'b00) begin n_err++; $display("FAIL single_norepeat: cycle %0d got %b want 00", i, {valid_a, busy_a}); end
    end
    d = 4'b0000;
    step();
  endtask
  task automatic test_fixed_priority();
    out_ready = 1'b1;
    d = 4'b1111;
    step();
    d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({valid_a, code_a} !== {1'b1, 2'(i)}) begin n_err++; $display("FAIL fixed_order: slot %0d got %b want %b", i, {valid_a, code_a}, {1'b1, 2'(i)}); end
    end
    step();
    n_cmp++; if ({valid_a, busy_a} !== 2'b00) begin n_err++; $display("FAIL fixed_idle: got %b want 00", {valid_a, busy_a}); end
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    d = 4'b1000;
    step();
    d = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if ({valid_a, code_a} !== 3'b111) begin n_err++; $display("FAIL bp_stable: cycle %0d got %b want 111", i, {valid_a, code_a}); end
    end
    for (int i = 0; i < 4; i++) begin
      d = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      step();
    end
    n_cmp++; if ({valid_a, code_a} !== 3'b111) begin n_err++; $display("FAIL bp_hold: got %b want 111", {valid_a, code_a}); end
    n_cmp++; if (ovf_a !== 8'd1) begin n_err++; $display("FAIL bp_drop: got %0d want 1", ovf_a); end
    out_ready = 1'b1;
    step();
    n_cmp++; if ({valid_a, code_a} !== 3'b111) begin n_err++; $display("FAIL bp_pended: got %b want 111", {valid_a, code_a}); end
    step();
    n_cmp++; if ({valid_a, busy_a} !== 2'b00) begin n_err++; $display("FAIL bp_drain: got %b want 00", {valid_a, busy_a}); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf_a !== 8'd0) begin n_err++; $display("FAIL bp_clr: got %0d want 0", ovf_a); end
  endtask
  task automatic test_round_robin();
    do_reset();
    out_ready = 1'b1;
    d = 4'b1111;
    step();
    for (int i = 0; i < 12; i++) begin
      d = (i % 2 == 0) ? 4'b0000 : 4'b1111;
      step();
      n_cmp++; if ({valid_b, code_b} !== {1'b1, 2'(i % 4)}) begin n_err++; $display("FAIL rr_order: slot %0d got %b want %b", i, {valid_b, code_b}, {1'b1, 2'(i % 4)}); end
    end
    d = 4'b0000;
  endtask
  task automatic test_overflow();
    logic [1:0] exp_c [5];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    out_ready = 1'b0;
    d = 4'b0001;
    step();
    d = 4'b0000;
    step();
    d = 4'b0001;
    step();
    for (int i = 0; i < 5; i++) begin
      d = 4'b0000;
      step();
      d = 4'b0001;
      step();
      n_cmp++; if (ovf_c !== exp_c[i]) begin n_err++; $display("FAIL ovf_sat: drop %0d got %0d want %0d", i, ovf_c, exp_c[i]); end
    end
    d = 4'b0000;
    step();
    d = 4'b0001;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_cmp++; if ({ovf_c, ovf_a} !== 10'h0) begin n_err++; $display("FAIL ovf_clr_wins: got %0d/%0d want 0/0", ovf_c, ovf_a); end
    d = 4'b0000;
    step();
    d = 4'b0110;
    step();
    d = 4'b0000;
    step();
    d = 4'b0111;
    step();
    n_cmp++; if (ovf_a !== 8'd3) begin n_err++; $display("FAIL ovf_multi: got %0d want 3", ovf_a); end
    n_cmp++; if (ovf_c !== 2'd3) begin n_err++; $display("FAIL ovf_multi_sat: got %0d want 3", ovf_c); end
  endtask
  initial begin
    rst = 1'b1;
    d = 4'b0000;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    step();
    step();
    n_cmp++; if ({valid_a, code_a, busy_a, ovf_a, valid_b, busy_b, ovf_c} !== 17'h0) begin n_err++; $display("FAIL reset_state: got %h want 0", {valid_a, code_a, busy_a, ovf_a, valid_b, busy_b, ovf_c}); end
    rst = 1'b0;
    step();
    test_reset();
    test_single();
    test_fixed_priority();
    test_backpressure();
    test_round_robin();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
